// File: rtl/adder_bist.sv
// adder_bist: built-in self test that drives a combinational adder with LFSR vectors and checks sum/cout/of.
// Define ADDER_BIST_DIRECTED_EN to prepend 8 directed corner-case vectors to every run.
module adder_bist #(
    parameter int WIDTH         = 32,
    parameter int NUM_VECTORS   = 256,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      fail_count,
    output logic [15:0]      first_fail_idx,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    input  logic             dut_of
);
    localparam logic [31:0] SEED_A = 32'hACE12468;
    localparam logic [31:0] SEED_B = 32'h13579BDF;
    localparam logic [31:0] TAPS   = 32'h80200003;
`ifdef ADDER_BIST_DIRECTED_EN
    localparam int NUM_DIR = 8;
`else
    localparam int NUM_DIR = 0;
`endif
    localparam int TOTAL = NUM_VECTORS + NUM_DIR;

    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

    state_t            state, state_n;
    logic [16:0]       idx, idx_n;
    logic [3:0]        cnt;
    logic [31:0]       lfsr_a, lfsr_b, lfsr_a_n, lfsr_b_n;
    logic              go, last, mismatch, exp_of;
    logic [WIDTH-1:0]  vec_a, vec_b;
    logic              vec_cin;
    logic [WIDTH:0]    exp_full;

    function automatic logic [31:0] step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? TAPS : 32'h0);
    endfunction

`ifdef ADDER_BIST_DIRECTED_EN
    function automatic logic [64:0] dir_vec(input logic [2:0] i);
        case (i)
            3'd0:    return {32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0};
            3'd1:    return {32'h8FFFFFFF, 32'h8FFFFFFF, 1'b0};
            3'd2:    return {32'h000007AA, 32'hFFFFFFFF, 1'b0};
            3'd3:    return {32'h000000AF, 32'h000000AF, 1'b1};
            3'd4:    return {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
            3'd5:    return {32'h00000123, 32'hFFFFF123, 1'b0};
            3'd6:    return {32'hFFFFF999, 32'h00000111, 1'b0};
            default: return {32'h00000000, 32'hFFFFFFFF, 1'b0};
        endcase
    endfunction

    logic [64:0] dv;
    logic        use_dir;
    always_comb begin
        dv      = dir_vec(idx_n[2:0]);
        use_dir = idx_n[16:3] == 14'd0;
        vec_a   = use_dir ? WIDTH'(dv[64:33]) : WIDTH'(lfsr_a_n);
        vec_b   = use_dir ? WIDTH'(dv[32:1]) : WIDTH'(lfsr_b_n);
        vec_cin = use_dir ? dv[0] : lfsr_a_n[31] ^ lfsr_b_n[0];
    end
`else
    always_comb begin
        vec_a   = WIDTH'(lfsr_a_n);
        vec_b   = WIDTH'(lfsr_b_n);
        vec_cin = lfsr_a_n[31] ^ lfsr_b_n[0];
    end
`endif

    assign go   = start && (state == IDLE || state == DONE);
    assign last = idx == 17'(TOTAL - 1);
    assign busy = state == APPLY || state == SETTLE || state == CHECK;
    assign done = state == DONE;
    assign pass = done && fail_count == 16'd0;

    // Next vector is computed from the post-update LFSR/index so the operands land as APPLY is entered.
    assign lfsr_a_n = go ? SEED_A : state == CHECK ? step(lfsr_a) : lfsr_a;
    assign lfsr_b_n = go ? SEED_B : state == CHECK ? step(lfsr_b) : lfsr_b;
    assign idx_n    = go ? 17'd0 : state == CHECK ? idx + 17'd1 : idx;

    assign exp_full = {1'b0, dut_a} + {1'b0, dut_b} + {{WIDTH{1'b0}}, dut_cin};
    assign exp_of   = (dut_a[WIDTH-1] == dut_b[WIDTH-1]) && (exp_full[WIDTH-1] != dut_a[WIDTH-1]);
    assign mismatch = {dut_cout, dut_sum, dut_of} != {exp_full, exp_of};

    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = go ? APPLY : state;
            APPLY:      state_n = SETTLE_CYCLES == 0 ? CHECK : SETTLE;
            SETTLE:     state_n = cnt == 4'(SETTLE_CYCLES - 1) ? CHECK : SETTLE;
            CHECK:      state_n = last ? DONE : APPLY;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else     state <= state_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_a         <= SEED_A;
            lfsr_b         <= SEED_B;
            idx            <= 17'd0;
            cnt            <= 4'd0;
            dut_a          <= '0;
            dut_b          <= '0;
            dut_cin        <= 1'b0;
            fail_count     <= 16'd0;
            first_fail_idx <= 16'hFFFF;
        end else begin
            lfsr_a <= lfsr_a_n;
            lfsr_b <= lfsr_b_n;
            idx    <= idx_n;
            cnt    <= state == SETTLE ? cnt + 4'd1 : 4'd0;
            if (state_n == APPLY) begin
                dut_a   <= vec_a;
                dut_b   <= vec_b;
                dut_cin <= vec_cin;
            end
            if (go) begin
                fail_count     <= 16'd0;
                first_fail_idx <= 16'hFFFF;
            end else if (state == CHECK && mismatch) begin
                fail_count <= fail_count == 16'hFFFF ? fail_count : fail_count + 16'd1;
                if (fail_count == 16'd0) first_fail_idx <= idx[15:0];
            end
        end
    end
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: scoreboard bench for adder_bist; models the LFSR vector stream and an adder with optional stuck-at-0 carry.
module tb_adder_bist;
    logic clk = 0, rst = 1, st0 = 0, st1 = 0, flt = 0;
    always #5 clk = ~clk;

    logic        busy0, done0, pass0, cin0, cout0, of0;
    logic [15:0] fc0, ff0;
    logic [31:0] a0, b0, sum0;
    logic [32:0] full0;
    logic        busy1, done1, pass1, cin1, cout1, of1;
    logic [15:0] fc1, ff1;
    logic [7:0]  a1, b1, sum1;
    logic [8:0]  full1;

    assign full0 = {1'b0, a0} + {1'b0, b0} + 33'(cin0);
    assign sum0  = full0[31:0];
    assign cout0 = flt ? 1'b0 : full0[32];
    assign of0   = (a0[31] == b0[31]) && (sum0[31] != a0[31]);
    assign full1 = {1'b0, a1} + {1'b0, b1} + 9'(cin1);
    assign sum1  = full1[7:0];
    assign cout1 = full1[8];
    assign of1   = (a1[7] == b1[7]) && (sum1[7] != a1[7]);

    adder_bist #(.WIDTH(32), .NUM_VECTORS(256), .SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .start(st0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fc0), .first_fail_idx(ff0), .dut_a(a0), .dut_b(b0), .dut_cin(cin0),
        .dut_sum(sum0), .dut_cout(cout0), .dut_of(of0));
    adder_bist #(.WIDTH(8), .NUM_VECTORS(6), .SETTLE_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .start(st1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .first_fail_idx(ff1), .dut_a(a1), .dut_b(b1), .dut_cin(cin1),
        .dut_sum(sum1), .dut_cout(cout1), .dut_of(of1));

`ifdef ADDER_BIST_DIRECTED_EN
    localparam int ND = 8;
    logic [31:0] da [8] = '{32'h7FFFFFFF, 32'h8FFFFFFF, 32'h7AA, 32'hAF, 32'hFFFFFFFF, 32'h123, 32'hFFFFF999, 32'h0};
    logic [31:0] db [8] = '{32'h7FFFFFFF, 32'h8FFFFFFF, 32'hFFFFFFFF, 32'hAF, 32'hFFFFFFFF, 32'hFFFFF123, 32'h111, 32'hFFFFFFFF};
    logic        dc [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    localparam int ND = 0;
`endif

    typedef struct {logic [31:0] a, b; logic cin;} vec_t;
    typedef struct {logic f; int abort_at; logic poke; logic exp_pass;} run_t;
    vec_t sb[$];
    int total = 0, bad = 0;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 20) $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] lstep(input logic [31:0] x);
        return x[0] ? (x >> 1) ^ 32'h80200003 : x >> 1;
    endfunction

    // Pushes the expected operand stream; nf/ff describe the result with cout stuck at 0.
    task automatic gen(input int n, input int w, output int nf, output int ff);
        logic [31:0] la, lb, m;
        logic [63:0] s;
        vec_t v;
        la = 32'hACE12468;
        lb = 32'h13579BDF;
        m  = w >= 32 ? 32'hFFFFFFFF : (32'h1 << w) - 32'h1;
        nf = 0;
        ff = 65535;
        for (int i = 0; i < n + ND; i++) begin
            v.a = la & m;
            v.b = lb & m;
            v.cin = la[31] ^ lb[0];
`ifdef ADDER_BIST_DIRECTED_EN
            if (i < 8) begin
                v.a = da[i] & m;
                v.b = db[i] & m;
                v.cin = dc[i];
            end
`endif
            s = 64'(v.a) + 64'(v.b) + 64'(v.cin);
            if (s[w]) begin
                if (nf == 0) ff = i;
                nf++;
            end
            sb.push_back(v);
            la = lstep(la);
            lb = lstep(lb);
        end
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {busy0, done0, pass0, fc0, ff0, a0, b0, cin0},
            {1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF, 32'h0, 32'h0, 1'b0});
    endtask

    task automatic run0(input run_t r);
        int nf, ff;
        vec_t v;
        flt = r.f;
        sb.delete();
        gen(256, 32, nf, ff);
        @(negedge clk) st0 = 1;
        @(negedge clk) st0 = 0;
        for (int k = 0; k < 256 + ND; k++) begin
            v = sb.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (k == r.abort_at && c == 0) begin
                    rst = 1;
                    @(negedge clk);
                    chk_reset("mid_reset");
                    rst = 0;
                    return;
                end
                chk("vec0", {busy0, done0, a0, b0, cin0}, {1'b1, 1'b0, v.a, v.b, v.cin});
                st0 = r.poke && k == 3 && c == 1;
                @(negedge clk);
            end
        end
        st0 = 0;
        chk("end0", {busy0, done0, pass0, fc0, ff0},
            {1'b0, 1'b1, r.exp_pass, r.f ? 16'(nf) : 16'h0, r.f ? 16'(ff) : 16'hFFFF});
    endtask

    run_t runs[5] = '{'{1'b0, -1, 1'b1, 1'b1}, '{1'b1, -1, 1'b0, 1'b0}, '{1'b1, -1, 1'b0, 1'b0},
                      '{1'b0, 10, 1'b0, 1'b0}, '{1'b0, -1, 1'b0, 1'b1}};

    initial begin
        int nf, ff;
        vec_t v;
        repeat (3) @(negedge clk);
        chk_reset("reset0");
        chk("reset1", {busy1, done1, pass1, fc1, ff1, a1, b1, cin1},
            {1'b0, 1'b0, 1'b0, 16'h0, 16'hFFFF, 8'h0, 8'h0, 1'b0});
        rst = 0;
        foreach (runs[i]) run0(runs[i]);
        sb.delete();
        gen(6, 8, nf, ff);
        @(negedge clk) st1 = 1;
        @(negedge clk) st1 = 0;
        for (int k = 0; k < 6 + ND; k++) begin
            v = sb.pop_front();
            for (int c = 0; c < 2; c++) begin
                chk("vec1", {busy1, a1, b1, cin1}, {1'b1, v.a[7:0], v.b[7:0], v.cin});
                @(negedge clk);
            end
        end
        chk("end1", {busy1, done1, pass1, fc1, ff1}, {1'b0, 1'b1, 1'b1, 16'h0, 16'hFFFF});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
